// File: rtl/mux_sel_scheduler.sv
// Round-robin owner of the 8:1 bit-mux select: grants one requester at a time,
// holds sel for a burst of up to MAX_BURST accepted beats, then rotates.
module mux_sel_scheduler #(
    parameter int N_REQ     = 8,
    parameter int SEL_W     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic             found;
    logic [SEL_W-1:0] pick;
    logic             transfer;
    logic             last_beat;
    logic             rel;

    // Scan downward from the farthest offset so the requester closest to ptr
    // is the last assignment and wins, without needing an early exit.
    always_comb begin
        // NOTE: every variable gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        found = 1'b0;
        pick  = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            logic [SEL_W-1:0] idx;
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign busy      = (state == GRANT);
    assign valid     = busy & req[sel];
    assign transfer  = valid & ready;
    assign last_beat = transfer && (beat_cnt == CNT_W'(MAX_BURST - 1));
    // A withdrawn request forces valid low, so it can never coincide with a
    // counted transfer: both causes collapse into one release.
    assign rel       = busy && (!req[sel] || last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            grant    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side reads the pre-edge value regardless of order.
            case (state)
                IDLE: begin
                    if (en && found) begin
                        state    <= GRANT;
                        sel      <= pick;
                        grant    <= N_REQ'(1) << pick;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state    <= IDLE;
                        grant    <= '0;
                        ptr      <= sel + SEL_W'(1);
                        beat_cnt <= '0;
                    end else if (transfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_grant_sel    : assert property (@(posedge clk) disable iff (!rst_n) busy |-> grant[sel]);
    a_cnt_bound    : assert property (@(posedge clk) disable iff (!rst_n) beat_cnt <= CNT_W'(MAX_BURST));

endmodule
